// File: rtl/dyse_trace_pkg.sv
// rtl/dyse_trace_pkg.sv - shared types and constants for the state trace serializer
//
// Purpose: frame FSM state type, drop counter width and a ceiling-divide
//          helper used to size the round-number header.
// Ports:   none (package)
package dyse_trace_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } trace_state_t;

  localparam int DROP_CNT_W = 16;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/state_trace_serializer_snapshot_fifo.sv
// rtl/state_trace_serializer_snapshot_fifo.sv - snapshot buffer for the state trace serializer
//
// Purpose: DEPTH-entry FIFO of captured snapshots. The head entry is read
//          combinationally so the serializer can mux words out of it.
// Ports:   clk, rst (sync, active-low)
//          push, push_data      write an entry (accepted when not full, or
//                               when a pop happens in the same cycle)
//          pop                  drop the head entry
//          full, empty, count   occupancy
//          head                 current head entry
module snapshot_fifo #(
  parameter int ENTRY_W = 74,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [ENTRY_W-1:0]       head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               do_push, do_pop;

  assign full  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A full buffer can still take a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/state_trace_serializer.sv
// rtl/state_trace_serializer.sv - captures state snapshots and streams them as framed words
//
// Purpose: on each snap pulse, buffers {round_in, state_in} and streams every
//          snapshot as HDR_WORDS round-number words followed by DAT_WORDS
//          state words, least-significant word first, over valid/ready.
// Ports:   clk, rst (sync, active-low)
//          snap, state_in, round_in          capture side
//          out_data, out_valid, out_ready,   host stream; out_last marks the
//          out_last                          final state word of a frame
//          busy                              buffer non-empty or frame active
//          overflow, dropped_count           sticky drop flag, saturating count
module state_trace_serializer
  import dyse_trace_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4,
  parameter int RND_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  snap,
  input  logic [WIDTH-1:0]      state_in,
  input  logic [RND_W-1:0]      round_in,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  overflow,
  output logic [DROP_CNT_W-1:0] dropped_count
);

  localparam int HDR_WORDS = ceil_div(RND_W, OUT_W);
  localparam int DAT_WORDS = WIDTH / OUT_W;
  localparam int HDR_BITS  = HDR_WORDS * OUT_W;
  localparam int ENTRY_W   = RND_W + WIDTH;
  localparam int MAX_WORDS = (DAT_WORDS > HDR_WORDS) ? DAT_WORDS : HDR_WORDS;
  localparam int IDX_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int CNT_W     = $clog2(DEPTH) + 1;

  trace_state_t          state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  overflow_q, overflow_d;
  logic [DROP_CNT_W-1:0] dropped_q, dropped_d;

  logic                  fifo_full, fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [ENTRY_W-1:0]    head;
  logic [WIDTH-1:0]      head_state;
  logic [HDR_BITS-1:0]   rnd_ext;

  logic                  xfer;
  logic                  last_xfer;
  logic                  push;
  logic                  drop;

  snapshot_fifo #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({round_in, state_in}),
    .pop       (last_xfer),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head),
    .count     (fifo_count)
  );

  assign head_state = head[WIDTH-1:0];
  assign rnd_ext    = HDR_BITS'(head[ENTRY_W-1:WIDTH]);

  assign out_valid = (state_q != IDLE);
  assign out_last  = (state_q == DATA) && (idx_q == IDX_W'(DAT_WORDS - 1));
  assign busy      = !fifo_empty || (state_q != IDLE);
  assign xfer      = out_valid && out_ready;
  assign last_xfer = xfer && out_last;

  // The slot freed by a finishing frame is reusable in the same cycle.
  assign push = snap && (!fifo_full || last_xfer);
  assign drop = snap && !push;

  always_comb begin
    out_data = '0;
    case (state_q)
      HDR:     out_data = rnd_ext[idx_q*OUT_W +: OUT_W];
      DATA:    out_data = head_state[idx_q*OUT_W +: OUT_W];
      default: out_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = HDR;
          idx_d   = '0;
        end
      end
      HDR: begin
        if (xfer) begin
          if (idx_q == IDX_W'(HDR_WORDS - 1)) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          if (out_last) begin
            idx_d = '0;
            // Occupancy after this pop and any same-cycle push decides
            // whether the next frame follows without a bubble.
            if ((fifo_count > CNT_W'(1)) || push) begin
              state_d = HDR;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_comb begin
    overflow_d = overflow_q | drop;
    dropped_d  = dropped_q;
    if (drop && (dropped_q != '1)) begin
      dropped_d = dropped_q + 1'b1;
    end
  end

  assign overflow      = overflow_q;
  assign dropped_count = dropped_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      overflow_q <= 1'b0;
      dropped_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
      dropped_q  <= dropped_d;
    end
  end

endmodule
